// File: rtl/dclk_bus_bridge.sv
// dclk_bus_bridge: clk-domain endpoint for the divided CPU clock (dclk).
// Each slow-side request, sampled at the dclk fall, becomes a single clk-wide
// m_req pulse. The response is presented on s_done/s_err/s_rdata only while
// dclk is low and is held until the next dclk rise has been observed.
module dclk_bus_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dclk,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_done,
  output logic              s_err,
  output logic [DATA_W-1:0] s_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic             dclk_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic             err_pend;

  // dclk edges seen one clk late; this lag is what keeps s_done valid past the slow-side capture edge
  assign rise = dclk & ~dclk_q;
  assign fall = ~dclk & dclk_q;

  // Request/response sequencing, edge-detect history and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dclk_q   <= 1'b0;
      cnt      <= '0;
      err_pend <= 1'b0;
      s_done   <= 1'b0;
      s_err    <= 1'b0;
      s_rdata  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      dclk_q <= dclk;
      m_req  <= 1'b0;
      case (state)
        // s_req is only looked at mid slow period, where it is guaranteed stable
        IDLE: begin
          if (fall && s_req && !s_done) begin
            m_we    <= s_we;
            m_addr  <= s_addr;
            m_wdata <= s_wdata;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          m_req <= 1'b1;
          cnt   <= '0;
          state <= WAIT;
        end
        // Ack is checked first so it beats a simultaneous terminal count
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (m_ack) begin
            s_rdata  <= m_rdata;
            err_pend <= 1'b0;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            s_rdata  <= '0;
            err_pend <= 1'b1;
            state    <= RESP;
          end
        end
        // Publish only while dclk is settled low so s_done never moves near a rise
        RESP: begin
          if (!dclk && !fall) begin
            s_done <= 1'b1;
            s_err  <= err_pend;
            state  <= DONE;
          end
        end
        DONE: begin
          if (rise) begin
            s_done <= 1'b0;
            s_err  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
